rc4_stream_gen: RTL and testbench

Parametrised RC4 keystream generator and the successor to the fixed 8-bit, fixed-key-array RC4 core. It holds an internal key buffer with runtime key length and runs init, KSA, optional RC4-drop[N] discard and PRGA from a flop-based S-box. It streams one keystream word per handshake to the downstream XOR/cipher stage over a valid/ready interface. It sits between the key-load register interface and the cipher datapath.

---
 rtl/rc4_stream_gen_pkg.sv | 19 +
 rtl/rc4_stream_gen_if.sv | 11 +
 rtl/rc4_stream_gen_sbox_regfile.sv | 34 +++
 rtl/rc4_stream_gen.sv | 172 +++++++++++++++++
 tb/tb_rc4_stream_gen.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rc4_stream_gen_pkg.sv
// Shared types and default sizing for the RC4 keystream generator.
package rc4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA_J,
    ST_KSA_SWAP,
    ST_PRGA_IJ,
    ST_PRGA_SWAP,
    ST_PRGA_LOAD,
    ST_EMIT
  } rc4_state_t;

  localparam int WORD_W_DEF      = 8;
  localparam int KEY_MAX_LEN_DEF = 32;
  localparam int DROP_N_DEF      = 0;

endpackage

// File: rtl/rc4_stream_gen_if.sv
// Keystream valid/ready channel from the generator to the cipher datapath.
interface rc4_stream_gen_if #(
  parameter int WORD_W = rc4_pkg::WORD_W_DEF
) ();
  logic              ks_valid;
  logic              ks_ready;
  logic [WORD_W-1:0] ks_data;

  modport master (output ks_valid, output ks_data, input ks_ready);
  modport slave  (input ks_valid, input ks_data, output ks_ready);
endinterface

// File: rtl/rc4_stream_gen_sbox_regfile.sv
// Flop-based S-box: two combinational read ports, two write ports.
module sbox_regfile #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic [WORD_W-1:0] rd_addr_a,
  output logic [WORD_W-1:0] rd_data_a,
  input  logic [WORD_W-1:0] rd_addr_b,
  output logic [WORD_W-1:0] rd_data_b,
  input  logic              we_a,
  input  logic [WORD_W-1:0] wr_addr_a,
  input  logic [WORD_W-1:0] wr_data_a,
  input  logic              we_b,
  input  logic [WORD_W-1:0] wr_addr_b,
  input  logic [WORD_W-1:0] wr_data_b
);
  localparam int DEPTH = 1 << WORD_W;

  logic [WORD_W-1:0] mem [DEPTH];
  logic              same_addr;

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

  // A swap of an entry with itself leaves it untouched.
  assign same_addr = we_a && we_b && (wr_addr_a == wr_addr_b);

  always_ff @(posedge clk) begin
    if (!same_addr) begin
      if (we_a) mem[wr_addr_a] <= wr_data_a;
      if (we_b) mem[wr_addr_b] <= wr_data_b;
    end
  end
endmodule

// File: rtl/rc4_stream_gen.sv
// RC4 keystream generator: key buffer, init/KSA/drop/PRGA sequencer, S-box.
module rc4_stream_gen
  import rc4_pkg::*;
#(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int KEY_MAX_LEN = KEY_MAX_LEN_DEF,
  parameter int DROP_N      = DROP_N_DEF,
  localparam int KA_W       = $clog2(KEY_MAX_LEN),
  localparam int KL_W       = $clog2(KEY_MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_wr_en,
  input  logic [KA_W-1:0]   key_wr_addr,
  input  logic [WORD_W-1:0] key_wr_data,
  input  logic [KL_W-1:0]   key_len,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              ks_ready_o,
  rc4_stream_gen_if.master  ks
);
  localparam int DC_W = (DROP_N > 0) ? $clog2(DROP_N + 1) : 1;
  localparam logic [WORD_W-1:0] IDX_ONE = WORD_W'(1);
  localparam logic [WORD_W-1:0] IDX_MAX = '1;

  rc4_state_t        state;
  logic [WORD_W-1:0] i, j, t;
  logic [KA_W-1:0]   kidx, klast;
  logic [DC_W-1:0]   drop_cnt;
  logic              ks_valid_r;
  logic [WORD_W-1:0] ks_data_r;

  logic [WORD_W-1:0] key_mem [KEY_MAX_LEN];

  logic [WORD_W-1:0] rd_a, rd_b, s_a, s_b;
  logic              we_a, we_b;
  logic [WORD_W-1:0] wa_a, wa_b, wd_a, wd_b;

  function automatic logic [KA_W-1:0] last_idx(input logic [KL_W-1:0] len);
    if (len == '0 || int'(len) > KEY_MAX_LEN) return KA_W'(KEY_MAX_LEN - 1);
    return KA_W'(int'(len) - 1);
  endfunction

  assign ks.ks_valid = ks_valid_r;
  assign ks.ks_data  = ks_data_r;

  always_ff @(posedge clk) begin
    if (key_wr_en && !busy && int'(key_wr_addr) < KEY_MAX_LEN)
      key_mem[key_wr_addr] <= key_wr_data;
  end

  // Port A follows i (or i+1 / t in PRGA), port B follows j; swaps cross the read data.
  always_comb begin
    rd_a = i;
    rd_b = j;
    we_a = 1'b0;
    we_b = 1'b0;
    wa_a = i;
    wa_b = j;
    wd_a = s_b;
    wd_b = s_a;
    case (state)
      ST_INIT: begin
        we_a = 1'b1;
        wd_a = i;
      end
      ST_KSA_SWAP, ST_PRGA_SWAP: begin
        we_a = 1'b1;
        we_b = 1'b1;
      end
      ST_PRGA_IJ:   rd_a = i + IDX_ONE;
      ST_PRGA_LOAD: rd_a = t;
      default: ;
    endcase
  end

  sbox_regfile #(.WORD_W(WORD_W)) u_sbox (
    .clk       (clk),
    .rd_addr_a (rd_a),
    .rd_data_a (s_a),
    .rd_addr_b (rd_b),
    .rd_data_b (s_b),
    .we_a      (we_a),
    .wr_addr_a (wa_a),
    .wr_data_a (wd_a),
    .we_b      (we_b),
    .wr_addr_b (wa_b),
    .wr_data_b (wd_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      i          <= '0;
      j          <= '0;
      t          <= '0;
      kidx       <= '0;
      klast      <= '0;
      drop_cnt   <= '0;
      busy       <= 1'b0;
      ks_ready_o <= 1'b0;
      ks_valid_r <= 1'b0;
      ks_data_r  <= '0;
    end else if (stop) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      ks_ready_o <= 1'b0;
      ks_valid_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            klast <= last_idx(key_len);
            i     <= '0;
            j     <= '0;
            kidx  <= '0;
            busy  <= 1'b1;
            state <= ST_INIT;
          end
        end
        ST_INIT: begin
          i <= i + IDX_ONE;
          if (i == IDX_MAX) state <= ST_KSA_J;
        end
        ST_KSA_J: begin
          j     <= j + s_a + key_mem[kidx];
          kidx  <= (kidx == klast) ? '0 : kidx + KA_W'(1);
          state <= ST_KSA_SWAP;
        end
        ST_KSA_SWAP: begin
          i <= i + IDX_ONE;
          if (i == IDX_MAX) begin
            j          <= '0;
            drop_cnt   <= DC_W'(DROP_N);
            ks_ready_o <= (DROP_N == 0);
            state      <= ST_PRGA_IJ;
          end else begin
            state <= ST_KSA_J;
          end
        end
        ST_PRGA_IJ: begin
          i     <= i + IDX_ONE;
          j     <= j + s_a;
          state <= ST_PRGA_SWAP;
        end
        ST_PRGA_SWAP: begin
          t     <= s_a + s_b;
          state <= ST_PRGA_LOAD;
        end
        ST_PRGA_LOAD: begin
          if (drop_cnt != '0) begin
            drop_cnt <= drop_cnt - DC_W'(1);
            if (drop_cnt == DC_W'(1)) ks_ready_o <= 1'b1;
            state <= ST_PRGA_IJ;
          end else begin
            ks_data_r  <= s_a;
            ks_valid_r <= 1'b1;
            state      <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (ks.ks_ready) begin
            ks_valid_r <= 1'b0;
            state      <= ST_PRGA_IJ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rc4_stream_gen.sv
// Bench for rc4_stream_gen: known-answer vectors, drop, backpressure, stop, reset, 4-bit S-box.
module tb_rc4_stream_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_wr_en = 1'b0;
  logic [4:0] key_wr_addr = '0;
  logic [7:0] key_wr_data = '0;
  logic [5:0] key_len = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       busy8, rdy8, busy8d, rdy8d;

  logic       k4_en = 1'b0;
  logic [2:0] k4_addr = '0;
  logic [3:0] k4_data = '0;
  logic [3:0] k4_len = '0;
  logic       start4 = 1'b0;
  logic       stop4 = 1'b0;
  logic       busy4, rdy4;

  int errors = 0;
  int checks = 0;
  logic [7:0] q8[$];
  logic [7:0] q8d[$];
  logic [7:0] q4[$];
  bit         hold8 = 1'b0;
  logic [7:0] hold_d8;

  int ref_key[32];
  int ref_ks[16];

  typedef struct {
    logic [0:7][7:0] key;
    int              len;
    int              n;
    logic [0:9][7:0] ks;
  } vec_t;
  vec_t vt[3];

  rc4_stream_gen_if #(.WORD_W(8)) if_8 ();
  rc4_stream_gen_if #(.WORD_W(8)) if_8d ();
  rc4_stream_gen_if #(.WORD_W(4)) if_4 ();

  rc4_stream_gen #(.WORD_W(8), .KEY_MAX_LEN(32), .DROP_N(0)) u8 (
    .clk(clk), .rst(rst), .key_wr_en(key_wr_en), .key_wr_addr(key_wr_addr),
    .key_wr_data(key_wr_data), .key_len(key_len), .start(start), .stop(stop),
    .busy(busy8), .ks_ready_o(rdy8), .ks(if_8));

  rc4_stream_gen #(.WORD_W(8), .KEY_MAX_LEN(32), .DROP_N(4)) u8d (
    .clk(clk), .rst(rst), .key_wr_en(key_wr_en), .key_wr_addr(key_wr_addr),
    .key_wr_data(key_wr_data), .key_len(key_len), .start(start), .stop(stop),
    .busy(busy8d), .ks_ready_o(rdy8d), .ks(if_8d));

  rc4_stream_gen #(.WORD_W(4), .KEY_MAX_LEN(8), .DROP_N(0)) u4 (
    .clk(clk), .rst(rst), .key_wr_en(k4_en), .key_wr_addr(k4_addr),
    .key_wr_data(k4_data), .key_len(k4_len), .start(start4), .stop(stop4),
    .busy(busy4), .ks_ready_o(rdy4), .ks(if_4));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Plain software RC4, any word width up to 8.
  function automatic void rc4_ref(input int w, input int len, input int drop, input int n);
    int m, jj, ii, t, tmp;
    int s[256];
    m = 1 << w;
    for (int k = 0; k < m; k++) s[k] = k;
    jj = 0;
    for (int k = 0; k < m; k++) begin
      jj = (jj + s[k] + ref_key[k % len]) % m;
      tmp = s[k]; s[k] = s[jj]; s[jj] = tmp;
    end
    ii = 0; jj = 0;
    for (int k = 0; k < drop + n; k++) begin
      ii = (ii + 1) % m;
      jj = (jj + s[ii]) % m;
      tmp = s[ii]; s[ii] = s[jj]; s[jj] = tmp;
      t = (s[ii] + s[jj]) % m;
      if (k >= drop) ref_ks[k - drop] = s[t];
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && hold8) begin
      chk("hold_valid", 32'(if_8.ks_valid), 32'd1);
      chk("hold_data", 32'(if_8.ks_data), 32'(hold_d8));
    end
    hold8   = if_8.ks_valid && !if_8.ks_ready && !stop && !rst;
    hold_d8 = if_8.ks_data;
    if (if_8.ks_valid && if_8.ks_ready && q8.size() > 0)
      chk("ks8", 32'(if_8.ks_data), 32'(q8.pop_front()));
    if (if_8d.ks_valid && if_8d.ks_ready && q8d.size() > 0)
      chk("ks8_drop", 32'(if_8d.ks_data), 32'(q8d.pop_front()));
    if (if_4.ks_valid && if_4.ks_ready && q4.size() > 0)
      chk("ks4", 32'(if_4.ks_data), 32'(q4.pop_front()));
  end

  function automatic int qsize(input int which);
    case (which)
      0: return q8.size();
      1: return q8d.size();
      default: return q4.size();
    endcase
  endfunction

  task automatic wait_empty(input int which, input int budget, input bit rnd);
    int c = 0;
    while (qsize(which) != 0 && c < budget) begin
      if (rnd) if_8.ks_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      c++;
    end
    if (rnd) if_8.ks_ready = 1'b1;
    chk($sformatf("drain_q%0d", which), 32'(qsize(which)), 32'd0);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic write_key8(input int addr, input logic [7:0] data);
    key_wr_en = 1'b1; key_wr_addr = 5'(addr); key_wr_data = data;
    cycles(1);
    key_wr_en = 1'b0;
  endtask

  task automatic start8(input int len);
    key_len = 6'(len); start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic stop8();
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    chk("stop_busy", 32'(busy8), 32'd0);
    chk("stop_rdy_o", 32'(rdy8), 32'd0);
    chk("stop_valid", 32'(if_8.ks_valid), 32'd0);
  endtask

  task automatic latency8(input int exp8, input int exp8d);
    int c = 0, l8 = -1, l8d = -1;
    while (c < 2000 && (l8 < 0 || l8d < 0)) begin
      cycles(1);
      c++;
      if (l8 < 0 && if_8.ks_valid) begin
        l8 = c;
        chk("rdy_o_at_valid", 32'(rdy8), 32'd1);
      end
      if (l8d < 0 && if_8d.ks_valid) l8d = c;
    end
    chk("latency8", 32'(l8), 32'(exp8));
    chk("latency8_drop", 32'(l8d), 32'(exp8d));
  endtask

  initial begin
    vt[0].key = {8'h4B, 8'h65, 8'h79, 40'h0};
    vt[0].len = 3; vt[0].n = 10;
    vt[0].ks  = {8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    vt[1].key = {8'h57, 8'h69, 8'h6B, 8'h69, 32'h0};
    vt[1].len = 4; vt[1].n = 6;
    vt[1].ks  = {8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7, 32'h0};
    vt[2].key = {8'h53, 8'h65, 8'h63, 8'h72, 8'h65, 8'h74, 16'h0};
    vt[2].len = 6; vt[2].n = 8;
    vt[2].ks  = {8'h04, 8'hD4, 8'h6B, 8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59, 16'h0};
    if_8.ks_ready = 1'b1; if_8d.ks_ready = 1'b1; if_4.ks_ready = 1'b1;

    // Reset state
    cycles(3);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_rdy_o", 32'(rdy8), 32'd0);
    chk("rst_valid", 32'(if_8.ks_valid), 32'd0);
    chk("rst_data", 32'(if_8.ks_data), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_data4", 32'(if_4.ks_data), 32'd0);
    rst = 1'b0;
    cycles(1);

    // Known-answer vectors, with and without drop
    for (int v = 0; v < 3; v++) begin
      for (int a = 0; a < vt[v].len; a++) write_key8(a, vt[v].key[a]);
      start8(vt[v].len);
      chk("busy_after_start", 32'(busy8), 32'd1);
      for (int k = 0; k < vt[v].n; k++) q8.push_back(vt[v].ks[k]);
      for (int k = 4; k < vt[v].n; k++) q8d.push_back(vt[v].ks[k]);
      latency8(771, 783);
      wait_empty(0, 5000, 1'b0);
      wait_empty(1, 5000, 1'b0);
      chk("rdy_o_drop", 32'(rdy8d), 32'd1);
      stop8();
    end

    // Random backpressure on key "Key"
    for (int a = 0; a < 3; a++) write_key8(a, vt[0].key[a]);
    start8(3);
    for (int k = 0; k < 10; k++) q8.push_back(vt[0].ks[k]);
    wait_empty(0, 8000, 1'b1);
    stop8();

    // Stop during KSA; write while busy is ignored; stop+start same cycle not accepted
    for (int a = 0; a < 4; a++) write_key8(a, vt[1].key[a]);
    start8(4);
    cycles(2);
    chk("busy_before_wr", 32'(busy8), 32'd1);
    write_key8(0, 8'h00);
    cycles(300);
    stop8();
    key_len = 6'd4; start = 1'b1; stop = 1'b1;
    cycles(1);
    start = 1'b0; stop = 1'b0;
    chk("stop_start_busy", 32'(busy8), 32'd0);
    start8(4);
    for (int k = 0; k < 6; k++) q8.push_back(vt[1].ks[k]);
    for (int k = 4; k < 6; k++) q8d.push_back(vt[1].ks[k]);
    wait_empty(0, 5000, 1'b0);
    wait_empty(1, 5000, 1'b0);
    stop8();

    // Key length 0 and over-range both mean the full 32-word buffer
    for (int a = 0; a < 32; a++) begin
      ref_key[a] = (a * 13 + 5) & 8'hFF;
      write_key8(a, 8'(ref_key[a]));
    end
    for (int r = 0; r < 2; r++) begin
      start8(r == 0 ? 0 : 40);
      rc4_ref(8, 32, 0, 6);
      for (int k = 0; k < 6; k++) q8.push_back(8'(ref_ks[k]));
      rc4_ref(8, 32, 4, 6);
      for (int k = 0; k < 6; k++) q8d.push_back(8'(ref_ks[k]));
      wait_empty(0, 5000, 1'b0);
      wait_empty(1, 5000, 1'b0);
      stop8();
    end

    // Asynchronous reset while a word is held in EMIT
    if_8.ks_ready = 1'b0;
    start8(3);
    begin
      int c = 0;
      while (!if_8.ks_valid && c < 2000) begin cycles(1); c++; end
      chk("emit_reached", 32'(if_8.ks_valid), 32'd1);
    end
    cycles(2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy8), 32'd0);
    chk("arst_rdy_o", 32'(rdy8), 32'd0);
    chk("arst_valid", 32'(if_8.ks_valid), 32'd0);
    chk("arst_data", 32'(if_8.ks_data), 32'd0);
    chk("arst_busy_drop", 32'(busy8d), 32'd0);
    cycles(1);
    rst = 1'b0;
    if_8.ks_ready = 1'b1;
    cycles(1);

    // 4-bit S-box against the software model
    ref_key[0] = 10; ref_key[1] = 3; ref_key[2] = 7; ref_key[3] = 15; ref_key[4] = 1;
    for (int a = 0; a < 5; a++) begin
      k4_en = 1'b1; k4_addr = 3'(a); k4_data = 4'(ref_key[a]);
      cycles(1);
    end
    k4_en = 1'b0;
    rc4_ref(4, 5, 0, 8);
    k4_len = 4'd5; start4 = 1'b1;
    cycles(1);
    start4 = 1'b0;
    for (int k = 0; k < 8; k++) q4.push_back(8'(ref_ks[k]));
    begin
      int c = 0;
      while (!if_4.ks_valid && c < 500) begin cycles(1); c++; end
      chk("latency4", 32'(c), 32'd51);
    end
    wait_empty(2, 2000, 1'b0);
    chk("rdy_o4", 32'(rdy4), 32'd1);
    stop4 = 1'b1;
    cycles(1);
    stop4 = 1'b0;
    chk("stop_busy4", 32'(busy4), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
